// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - handshake controller around an external multi-cycle divider
// Optional div_rdy watchdog is enabled by defining DIV_CTRL_TIMEOUT_EN.
module div_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_num,
    input  logic [3:0] in_denom,
    output logic [7:0] div_num,
    output logic [3:0] div_denom,
    output logic       div_start,
    input  logic [3:0] div_quotient,
    input  logic [3:0] div_remainder,
    input  logic       div_rdy,
    input  logic       div_overflow,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_quotient,
    output logic [3:0] out_remainder,
    output logic       out_overflow,
    output logic       out_timeout
);
    typedef enum logic [2:0] {IDLE, START, SETTLE, WAIT, HOLD} state_t;
    state_t state;

`ifdef DIV_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          timeout_q;
    logic          expired;
    assign expired     = (cnt == CW'(TIMEOUT));
    assign out_timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign out_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            div_start     <= 1'b0;
            out_valid     <= 1'b0;
            div_num       <= 8'd0;
            div_denom     <= 4'd0;
            out_quotient  <= 4'd0;
            out_remainder <= 4'd0;
            out_overflow  <= 1'b0;
`ifdef DIV_CTRL_TIMEOUT_EN
            cnt           <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (in_denom != 4'd0) begin
                            div_num   <= in_num;
                            div_denom <= in_denom;
                            div_start <= 1'b1;
                            state     <= START;
                        end else begin
                            // divide-by-zero is answered locally, the divider is never started
                            out_quotient  <= 4'hF;
                            out_remainder <= 4'hF;
                            out_overflow  <= 1'b1;
`ifdef DIV_CTRL_TIMEOUT_EN
                            timeout_q     <= 1'b0;
`endif
                            out_valid     <= 1'b1;
                            state         <= HOLD;
                        end
                    end
                end
                START: state <= SETTLE;
                SETTLE: begin
                    // div_rdy may still be high from the previous operation here
`ifdef DIV_CTRL_TIMEOUT_EN
                    cnt <= cnt + CW'(1);
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_rdy) begin
                        out_quotient  <= div_quotient;
                        out_remainder <= div_remainder;
                        out_overflow  <= div_overflow;
`ifdef DIV_CTRL_TIMEOUT_EN
                        timeout_q     <= 1'b0;
                        cnt           <= '0;
`endif
                        out_valid     <= 1'b1;
                        state         <= HOLD;
                    end
`ifdef DIV_CTRL_TIMEOUT_EN
                    else if (expired) begin
                        out_quotient  <= 4'hF;
                        out_remainder <= 4'hF;
                        out_overflow  <= 1'b1;
                        timeout_q     <= 1'b1;
                        cnt           <= '0;
                        out_valid     <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
